if_stage: RTL

- Instruction-fetch stage of the pipelined ARM core: the producer of the PC/instruction pair that the decode stage consumes.
- Holds the program counter and drives a req/ack instruction-memory port.
- Handles stalls (freeze from hazard detection) and branch redirects (from EXE).
- Registers the IF/ID pipeline outputs: PC_out, INST, valid.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: req/ack request channel.
// master = fetch stage (req, addr out); slave = memory (ack, rdata out).
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, req/ack imem port, stall/redirect, IF/ID regs.
// Ports: clk, rst (async low), freeze, branch_taken/addr, imem bus, PC_out/INST/valid.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    if_stage_if.master  imem,
    output logic [31:0] PC_out,
    output logic [31:0] INST,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] fetch_addr_q;
    logic [31:0] hold_q;
    logic [31:0] pc_out_q;
    logic [31:0] inst_q;
    logic        valid_q;
    logic [31:0] fa_inc;

    assign fa_inc = fetch_addr_q + PC_STEP;

    assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
    assign imem.imem_addr = fetch_addr_q;

    assign PC_out = pc_out_q;
    assign INST   = inst_q;
    assign valid  = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            hold_q       <= 32'h0;
            pc_out_q     <= 32'h0;
            inst_q       <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    fetch_addr_q <= pc_q;
                    state_q      <= S_REQ;
                end
                S_REQ: begin
                    if (branch_taken) begin
                        pc_q     <= branch_addr;
                        pc_out_q <= 32'h0;
                        inst_q   <= 32'h0;
                        valid_q  <= 1'b0;
                        // An un-acked request cannot be withdrawn; wait it out.
                        if (imem.imem_ack) fetch_addr_q <= branch_addr;
                        else               state_q      <= S_DISCARD;
                    end else if (imem.imem_ack) begin
                        pc_q <= fa_inc;
                        if (freeze) begin
                            // Park the word; decode is stalled.
                            hold_q  <= imem.imem_rdata;
                            state_q <= S_HOLD;
                        end else begin
                            pc_out_q     <= fa_inc;
                            inst_q       <= imem.imem_rdata;
                            valid_q      <= 1'b1;
                            fetch_addr_q <= fa_inc;
                        end
                    end else if (!freeze) begin
                        pc_out_q <= 32'h0;
                        inst_q   <= 32'h0;
                        valid_q  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc_q         <= branch_addr;
                        fetch_addr_q <= branch_addr;
                        pc_out_q     <= 32'h0;
                        inst_q       <= 32'h0;
                        valid_q      <= 1'b0;
                        state_q      <= S_REQ;
                    end else if (!freeze) begin
                        // pc already holds the parked word's address + step.
                        pc_out_q     <= pc_q;
                        inst_q       <= hold_q;
                        valid_q      <= 1'b1;
                        fetch_addr_q <= pc_q;
                        state_q      <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    pc_out_q <= 32'h0;
                    inst_q   <= 32'h0;
                    valid_q  <= 1'b0;
                    if (branch_taken) pc_q <= branch_addr;
                    if (imem.imem_ack) begin
                        fetch_addr_q <= branch_taken ? branch_addr : pc_q;
                        state_q      <= S_REQ;
                    end
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

endmodule
